pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction-decode controller in the MIPS core.
- Holds the program counter and an instruction register, and runs an instruction-memory request/ready handshake.
- Presents op/func/imm fields to the controller and generates the controller's `enable` (processor freeze).
- Consumes the controller's `pcsel` to compute the next PC: sequential, branch, jump, or jump-register.

Parameters:
RESET_PC, 32'h0040_0000, byte address loaded into PC on reset
ADDR_BITS, 10, width of word address driven to instruction memory
MAX_WAIT, 15, max cycles in FETCH without imem_ready before fault; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pcsel  input  2  next-PC select from controller: 00 PC+4, 01 branch, 10 jump, 11 JR
jr_target  input  32  register-file read data used for JR
stall  input  1  external freeze request
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_BITS  word address, equal to pc[ADDR_BITS+1:2]
imem_rdata  input  32  instruction word from memory
imem_ready  input  1  memory has valid data on imem_rdata this cycle
instr  output  32  instruction register
op  output  6  instr[31:26]
func  output  6  instr[5:0]
imm  output  16  instr[15:0]
pc  output  32  current PC
pc_plus4  output  32  pc + 4, feeds JAL link-write path
enable  output  1  controller enable; register/memory writes happen only when high
fetch_fault  output  1  sticky: instruction fetch timed out

Behaviour:
- Reset (async, immediate, including mid-fetch): state=IDLE, pc=RESET_PC, instr=0 (decodes as SLL nop), enable=0, imem_req=0, fetch_fault=0, wait counter=0.
- FSM states: IDLE, FETCH, EXEC, FAULT.
- IDLE:
  - Lasts exactly one cycle after reset deasserts, then moves to FETCH.
  - imem_req=0, enable=0.
- FETCH:
  - imem_req=1; imem_addr is stable for the whole state; enable=0.
  - If imem_ready=1 at a rising edge: instr<=imem_rdata, wait counter cleared, move to EXEC.
  - Otherwise the wait counter increments.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT with ready still low: move to FAULT and set fetch_fault.
- EXEC:
  - imem_req=0; enable = ~stall (combinational).
  - If stall=1: stay in EXEC; pc and instr hold.
  - If stall=0: at the edge, pc<=next_pc and move to FETCH.
  - Exactly one enabled cycle per instruction.
- FAULT:
  - Absorbing until reset; enable=0, imem_req=0, fetch_fault=1.
- imem_ready is ignored outside FETCH.
- Best-case throughput: 2 cycles per instruction (FETCH with ready high in the same cycle, then EXEC).
- next_pc, all arithmetic mod 2^32 with silent wrap:
  - 00: pc_plus4
  - 01: pc_plus4 + (sign_extend(instr[15:0]) << 2)
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 11: {jr_target[31:2], 2'b00} (low two bits forced to zero)
- pcsel is sampled only at the EXEC→FETCH edge; its value at all other times is a don't-care.
- pc_plus4 is combinational from pc.
- op/func/imm are combinational slices of instr.
- imem_addr uses the low address bits of pc only; upper pc bits are ignored by memory.

Test Plan:
1. Assert reset, release; memory returns ready immediately → cycle after IDLE: imem_addr=0x000 (RESET_PC word-aligned into 10 bits) with imem_req=1; next cycle enable=1 and instr=imem_rdata. A pcsel=00 sequence yields pc 0x00400000, 0x00400004, 0x00400008, with enable high every other cycle.
2. Branch: pc=0x00400010, instr=0x1000FFFC (imm=-4), pcsel=01 → pc becomes 0x00400004. With imm=0x7FFF at pc=0xFFFFFFF0, the result wraps to 0x0001FFF0.
3. Jump/JR:
   - J: instr=0x08100005 at pc=0x00400000, pcsel=10 → pc=0x00400014.
   - JR: jr_target=0x00400103, pcsel=11 → pc=0x00400100.
4. Stall: hold stall=1 for 3 cycles in EXEC → enable=0, pc and instr unchanged; after stall drops, enable=1 for exactly one cycle, then pc advances.
5. Slow memory/timeout:
   - ready delayed 5 cycles → imem_addr held constant, enable=0 throughout, instr captured on the ready cycle.
   - ready never asserted with MAX_WAIT=15 → fetch_fault=1 after 15 FETCH cycles, enable stays 0.
6. Reset mid-operation: assert reset while in FETCH with a pending wait → imem_req=0, pc=RESET_PC, fetch_fault=0 immediately (no clock edge needed); normal fetch resumes after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage for the MIPS core: owns the PC and instruction register, runs the
// instruction-memory request/ready handshake and produces the controller enable.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          ADDR_BITS = 10,
    parameter int          MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           pcsel,
    input  logic [31:0]          jr_target,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ready,
    output logic [31:0]          instr,
    output logic [5:0]           op,
    output logic [5:0]           func,
    output logic [15:0]          imm,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 enable,
    output logic                 fetch_fault
);

    localparam int                WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t              state_r;
    logic [31:0]         pc_r;
    logic [31:0]         instr_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                imem_req_r;
    logic                exec_r;
    logic                fetch_fault_r;

    logic [31:0]         pc_plus4_s;
    logic [31:0]         next_pc_s;
    logic [WAIT_W-1:0]   wait_inc_s;
    logic                timeout_s;
    logic                unused_jr_bits_s;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] base, input logic [25:0] idx);
        return {base[31:28], idx, 2'b00};
    endfunction

    assign pc_plus4_s       = pc_r + 32'd4;
    assign wait_inc_s       = wait_cnt_r + WAIT_ONE;
    assign timeout_s        = (MAX_WAIT != 0) && (wait_inc_s == WAIT_LIMIT);
    assign unused_jr_bits_s = ^jr_target[1:0];

    // Next-PC selection; only consulted on the EXEC to FETCH edge.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (pcsel)
            2'b00:   next_pc_s = pc_plus4_s;
            2'b01:   next_pc_s = pc_plus4_s + branch_offset(instr_r[15:0]);
            2'b10:   next_pc_s = jump_target(pc_plus4_s, instr_r[25:0]);
            2'b11:   next_pc_s = {jr_target[31:2], 2'b00};
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Fetch/execute sequencer with its registered request, fault and exec flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0000_0000;
            wait_cnt_r    <= '0;
            imem_req_r    <= 1'b0;
            exec_r        <= 1'b0;
            fetch_fault_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                    exec_r     <= 1'b0;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr_r    <= imem_rdata;
                        wait_cnt_r <= '0;
                        state_r    <= ST_EXEC;
                        imem_req_r <= 1'b0;
                        exec_r     <= 1'b1;
                    end else if (timeout_s) begin
                        wait_cnt_r    <= wait_inc_s;
                        state_r       <= ST_FAULT;
                        imem_req_r    <= 1'b0;
                        fetch_fault_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_inc_s;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_r       <= next_pc_s;
                        state_r    <= ST_FETCH;
                        imem_req_r <= 1'b1;
                        exec_r     <= 1'b0;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_FAULT: begin
                    state_r       <= ST_FAULT;
                    imem_req_r    <= 1'b0;
                    exec_r        <= 1'b0;
                    fetch_fault_r <= 1'b1;
                end
                default: begin
                    state_r       <= ST_FAULT;
                    imem_req_r    <= 1'b0;
                    exec_r        <= 1'b0;
                    fetch_fault_r <= 1'b1;
                end
            endcase
        end
    end

    // enable follows stall combinationally so a freeze suppresses writes in the same cycle.
    assign enable      = exec_r & ~stall;
    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r[ADDR_BITS+1:2];
    assign instr       = instr_r;
    assign op          = instr_r[31:26];
    assign func        = instr_r[5:0];
    assign imm         = instr_r[15:0];
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_fault = fetch_fault_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the bench plays instruction memory, a
// behavioural model predicts every output each cycle, and literals pin the model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam int          ADDR_BITS = 10;
    localparam int          MAX_WAIT  = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           pcsel = 2'b00;
    logic [31:0]          jr_target = 32'h0000_0000;
    logic                 stall = 1'b0;
    logic                 imem_req;
    logic [ADDR_BITS-1:0] imem_addr;
    logic [31:0]          imem_rdata = 32'h0000_0000;
    logic                 imem_ready = 1'b0;
    logic [31:0]          instr;
    logic [5:0]           op;
    logic [5:0]           func;
    logic [15:0]          imm;
    logic [31:0]          pc;
    logic [31:0]          pc_plus4;
    logic                 enable;
    logic                 fetch_fault;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;
    logic [31:0] cur_pc;

    pc_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .ADDR_BITS (ADDR_BITS),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcsel       (pcsel),
        .jr_target   (jr_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .imm         (imm),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .enable      (enable),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_boot;
    logic        m_fetch;
    logic        m_exec;
    logic        m_dead;
    int          m_wait;

    function automatic logic [31:0] model_next_pc(input logic [31:0] cpc, input logic [31:0] ins,
                                                  input logic [1:0] sel, input logic [31:0] jrt);
        logic [31:0]        pc4;
        logic signed [31:0] sx;
        pc4 = cpc + 32'd4;
        sx  = signed'(ins[15:0]);
        case (sel)
            2'd1:    return pc4 + 32'(sx * 4);
            2'd2:    return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
            2'd3:    return jrt & 32'hFFFF_FFFC;
            default: return pc4;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    <= RESET_PC;
            m_instr <= 32'h0000_0000;
            m_boot  <= 1'b1;
            m_fetch <= 1'b0;
            m_exec  <= 1'b0;
            m_dead  <= 1'b0;
            m_wait  <= 0;
        end else if (m_dead) begin
            m_dead <= 1'b1;
        end else if (m_boot) begin
            m_boot  <= 1'b0;
            m_fetch <= 1'b1;
        end else if (m_fetch) begin
            if (imem_ready) begin
                m_instr <= imem_rdata;
                m_fetch <= 1'b0;
                m_exec  <= 1'b1;
                m_wait  <= 0;
            end else begin
                m_wait <= m_wait + 1;
                if (MAX_WAIT != 0 && m_wait + 1 == MAX_WAIT) begin
                    m_dead  <= 1'b1;
                    m_fetch <= 1'b0;
                end
            end
        end else if (m_exec && !stall) begin
            m_pc    <= model_next_pc(m_pc, m_instr, pcsel, jr_target);
            m_exec  <= 1'b0;
            m_fetch <= 1'b1;
        end
    end

    // Per-cycle comparison just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (cmp_on) begin
                chk("m_pc", pc, m_pc);
                chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("m_instr", instr, m_instr);
                chk("m_op", {26'd0, op}, m_instr >> 26);
                chk("m_func", {26'd0, func}, m_instr & 32'h0000_003F);
                chk("m_imm", {16'd0, imm}, m_instr & 32'h0000_FFFF);
                chk("m_addr", {22'd0, imem_addr}, (m_pc >> 2) & 32'h0000_03FF);
                chk("m_req", {31'd0, imem_req}, {31'd0, m_fetch});
                chk("m_enable", {31'd0, enable}, {31'd0, m_exec & ~stall});
                chk("m_fault", {31'd0, fetch_fault}, {31'd0, m_dead});
            end
        end
    end

    // One instruction: wait states, capture, stall cycles, then advance to exp_pc.
    task automatic run_instr(input logic [31:0] word, input logic [1:0] sel, input logic [31:0] jrt,
                             input int delay, input int stalls, input logic [31:0] exp_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            stall      = 1'($urandom);
            pcsel      = 2'($urandom);
            #1;
            chk("wait_enable", {31'd0, enable}, 32'd0);
            chk("wait_addr", {22'd0, imem_addr}, {22'd0, cur_pc[ADDR_BITS+1:2]});
            @(negedge clk);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        stall      = 1'($urandom);
        @(negedge clk);
        for (int s = 0; s < stalls; s++) begin
            stall      = 1'b1;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            pcsel      = 2'($urandom);
            #1;
            chk("stall_enable", {31'd0, enable}, 32'd0);
            chk("stall_pc", pc, cur_pc);
            chk("stall_instr", instr, word);
            @(negedge clk);
        end
        stall      = 1'b0;
        pcsel      = sel;
        jr_target  = jrt;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        #1;
        chk("exec_enable", {31'd0, enable}, 32'd1);
        chk("exec_instr", instr, word);
        @(negedge clk);
        #1;
        chk("next_pc", pc, exp_pc);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        cur_pc = exp_pc;
    endtask

    task automatic boot();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        chk("idle_enable", {31'd0, enable}, 32'd0);
        @(negedge clk);
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {22'd0, imem_addr}, 32'h0000_0000);
        cur_pc = RESET_PC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        cmp_on = 1'b1;
        boot();

        // sequential stream
        run_instr(32'h2408_0001, 2'b00, 32'h0, 0, 0, 32'h0040_0004);
        run_instr(32'h2409_0002, 2'b00, 32'h0, 0, 0, 32'h0040_0008);
        run_instr(32'h0000_0000, 2'b00, 32'h0, 0, 0, 32'h0040_000C);
        run_instr(32'h012A_4020, 2'b00, 32'h0, 0, 0, 32'h0040_0010);
        // branches, including wrap past 2^32
        run_instr(32'h1000_FFFC, 2'b01, 32'h0, 0, 0, 32'h0040_0004);
        run_instr(32'h03E0_0008, 2'b11, 32'hFFFF_FFF0, 0, 0, 32'hFFFF_FFF0);
        #1;
        chk("high_pc_addr", {22'd0, imem_addr}, 32'h0000_03FC);
        run_instr(32'h1000_7FFF, 2'b01, 32'h0, 1, 0, 32'h0001_FFF0);
        // jump and jump-register
        run_instr(32'h03E0_0008, 2'b11, 32'h0040_0000, 0, 0, 32'h0040_0000);
        run_instr(32'h0810_0005, 2'b10, 32'h0, 0, 0, 32'h0040_0014);
        run_instr(32'h0360_0008, 2'b11, 32'h0040_0103, 0, 0, 32'h0040_0100);
        // stall and slow memory
        run_instr(32'h2108_0001, 2'b00, 32'h0, 0, 3, 32'h0040_0104);
        run_instr(32'h8D09_0004, 2'b00, 32'h0, 5, 0, 32'h0040_0108);

        // asynchronous reset while a fetch is pending
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", pc, RESET_PC);
        chk("async_fault", {31'd0, fetch_fault}, 32'd0);
        chk("async_instr", instr, 32'h0000_0000);
        boot();
        run_instr(32'h2408_0007, 2'b00, 32'h0, 0, 0, 32'h0040_0004);

        // fetch timeout
        for (int i = 0; i < 14; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        #1;
        chk("pre_timeout_fault", {31'd0, fetch_fault}, 32'd0);
        chk("pre_timeout_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("timeout_fault", {31'd0, fetch_fault}, 32'd1);
        chk("timeout_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            stall      = 1'b0;
            @(negedge clk);
            #1;
            chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
            chk("fault_enable", {31'd0, enable}, 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
        chk("fault_rst_pc", pc, RESET_PC);
        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
